// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use hazard detection and
//               optional EX/MEM and MEM/WB operand forwarding (ID_EX_FORWARD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_alu_src,
    input  logic [2:0]       id_aluop,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             exmem_reg_write,
    input  logic [RA_W-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RA_W-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_op,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             load_use_hazard
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic             alu_src;
        logic [2:0]       aluop;
        logic [RA_W-1:0]  rs;
        logic [RA_W-1:0]  rt;
        logic [RA_W-1:0]  rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } ex_reg_t;

    ex_reg_t          r_ex;
    ex_reg_t          w_capture;
    logic             w_hazard;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;

    // A load in EX whose destination is read by the instruction in ID
    assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) && id_valid &&
                      ((r_ex.rd == id_rs) || (r_ex.rd == id_rt));

    always_comb begin
        w_capture           = '0;
        w_capture.valid     = id_valid;
        w_capture.rs_data   = id_rs_data;
        w_capture.rt_data   = id_rt_data;
        w_capture.imm       = id_imm;
        w_capture.alu_src   = id_alu_src;
        w_capture.aluop     = id_aluop;
        w_capture.rs        = id_rs;
        w_capture.rt        = id_rt;
        w_capture.rd        = id_rd;
        w_capture.reg_write = id_valid & id_reg_write;
        w_capture.mem_read  = id_valid & id_mem_read;
        w_capture.mem_write = id_valid & id_mem_write;
    end

    // Flush beats stall; the hazard bubble only applies when the stage is free to advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (flush) begin
            r_ex <= '0;
        end else if (stall) begin
            r_ex <= r_ex;
        end else if (w_hazard) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_capture;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards
    always_comb begin
        w_fwd_rs = r_ex.rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_ex.rs)) begin
            w_fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_ex.rs)) begin
            w_fwd_rs = memwb_result;
        end
    end

    always_comb begin
        w_fwd_rt = r_ex.rt_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_ex.rt)) begin
            w_fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_ex.rt)) begin
            w_fwd_rt = memwb_result;
        end
    end
`else
    logic w_unused_fwd;

    assign w_fwd_rs     = r_ex.rs_data;
    assign w_fwd_rt     = r_ex.rt_data;
    assign w_unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                            memwb_reg_write, memwb_rd, memwb_result, r_ex.rs, r_ex.rt};
`endif

    assign alu_in1         = w_fwd_rs;
    assign alu_in2         = r_ex.alu_src ? r_ex.imm : w_fwd_rt;
    assign alu_op          = r_ex.aluop;
    assign ex_valid        = r_ex.valid;
    assign ex_store_data   = w_fwd_rt;
    assign ex_rd           = r_ex.rd;
    assign ex_reg_write    = r_ex.reg_write;
    assign ex_mem_read     = r_ex.mem_read;
    assign ex_mem_write    = r_ex.mem_write;
    assign load_use_hazard = w_hazard;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed vector table,
//               hand-written stall/flush/reset sequences and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src;
    logic [2:0]  id_aluop;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [2:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alu_src(id_alu_src), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .ex_valid(ex_valid),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        vld;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic [2:0]  aluop;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw;
        logic        xm_rw;
        logic [4:0]  xm_rd;
        logic [31:0] xm_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic        e_haz_pre;
        logic        e_valid;
        logic [31:0] e_in1, e_in2;
        logic [2:0]  e_op;
        logic        e_rw;
        logic        e_haz_post;
    } vec_t;

    vec_t vt[6];

    task automatic apply_vec(input vec_t v);
        id_valid = v.vld; id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
        id_alu_src = v.alu_src; id_aluop = v.aluop; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
        exmem_reg_write = v.xm_rw; exmem_rd = v.xm_rd; exmem_result = v.xm_res;
        memwb_reg_write = v.wb_rw; memwb_rd = v.wb_rd; memwb_result = v.wb_res;
    endtask

    task automatic drive_id(input logic vld, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic rw);
        vec_t v;
        v = '0;
        v.vld = vld; v.rs_data = rsd; v.rt_data = rtd; v.aluop = op;
        v.rs = rs; v.rt = rt; v.rd = rd; v.rw = rw;
        apply_vec(v);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic [2:0]  aluop;
        logic [4:0]  rs, rt, rd;
        logic        rw, mr, mw;
    } st_t;

    st_t ms;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FORWARD_EN
        if (exmem_reg_write && r != 0 && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && r != 0 && memwb_rd == r) return memwb_result;
`endif
        return d;
    endfunction

    function automatic logic m_hazard(input st_t s);
        return s.valid && s.mr && s.rd != 0 && id_valid && (s.rd == id_rs || s.rd == id_rt);
    endfunction

    function automatic st_t m_next(input st_t s);
        st_t n;
        if (flush) return '0;
        if (stall) return s;
        if (m_hazard(s)) return '0;
        n.valid = id_valid; n.rs_data = id_rs_data; n.rt_data = id_rt_data; n.imm = id_imm;
        n.alu_src = id_alu_src; n.aluop = id_aluop; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
        n.rw = id_valid && id_reg_write;
        n.mr = id_valid && id_mem_read;
        n.mw = id_valid && id_mem_write;
        return n;
    endfunction

    task automatic check_model();
        logic [31:0] f_rt;
        f_rt = fwd(ms.rt, ms.rt_data);
        chk("rnd_alu_in1", alu_in1, fwd(ms.rs, ms.rs_data));
        chk("rnd_alu_in2", alu_in2, ms.alu_src ? ms.imm : f_rt);
        chk("rnd_store", ex_store_data, f_rt);
        chk("rnd_alu_op", {29'd0, alu_op}, {29'd0, ms.aluop});
        chk("rnd_valid", {31'd0, ex_valid}, {31'd0, ms.valid});
        chk("rnd_rd", {27'd0, ex_rd}, {27'd0, ms.rd});
        chk("rnd_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
            {29'd0, ms.rw, ms.mr, ms.mw});
        chk("rnd_hazard", {31'd0, load_use_hazard}, {31'd0, m_hazard(ms)});
    endtask

    initial begin
        vec_t z;
        z = '0;
        stall = 0; flush = 0; rst_n = 0;
        apply_vec(z);

        // reset state
        #2;
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_alu_op", {29'd0, alu_op}, 32'd0);
        chk("reset_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
        chk("reset_in1", alu_in1, 32'd0);
        chk("reset_hazard", {31'd0, load_use_hazard}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;

        // capture (3,7)
        vt[0] = '0;
        vt[0].vld = 1; vt[0].rs_data = 3; vt[0].rt_data = 7; vt[0].rs = 1; vt[0].rt = 2;
        vt[0].rd = 3; vt[0].rw = 1;
        vt[0].e_valid = 1; vt[0].e_in1 = 3; vt[0].e_in2 = 7; vt[0].e_rw = 1;
        // double-match forwarding priority on rs=8
        vt[1] = '0;
        vt[1].vld = 1; vt[1].rs_data = 20; vt[1].rt_data = 7; vt[1].aluop = 3'b010;
        vt[1].rs = 8; vt[1].rt = 2; vt[1].rd = 9;
        vt[1].xm_rw = 1; vt[1].xm_rd = 8; vt[1].xm_res = 5;
        vt[1].wb_rw = 1; vt[1].wb_rd = 8; vt[1].wb_res = 9;
        vt[1].e_valid = 1; vt[1].e_in2 = 7; vt[1].e_op = 3'b010;
`ifdef ID_EX_FORWARD_EN
        vt[1].e_in1 = 5;
`else
        vt[1].e_in1 = 20;
`endif
        // r0 never forwards; immediate selected
        vt[2] = '0;
        vt[2].vld = 1; vt[2].alu_src = 1; vt[2].imm = 10; vt[2].aluop = 3'b001; vt[2].rd = 6;
        vt[2].xm_rw = 1; vt[2].xm_rd = 0; vt[2].xm_res = 32'hFFFF_FFFF;
        vt[2].e_valid = 1; vt[2].e_in1 = 0; vt[2].e_in2 = 10; vt[2].e_op = 3'b001;
        // lw r4
        vt[3] = '0;
        vt[3].vld = 1; vt[3].rs_data = 11; vt[3].rt_data = 12; vt[3].imm = 4; vt[3].alu_src = 1;
        vt[3].rs = 1; vt[3].rt = 2; vt[3].rd = 4; vt[3].rw = 1; vt[3].mr = 1;
        vt[3].e_valid = 1; vt[3].e_in1 = 11; vt[3].e_in2 = 4; vt[3].e_rw = 1;
        // consumer of r4: hazard, bubble
        vt[4] = '0;
        vt[4].vld = 1; vt[4].rs_data = 33; vt[4].rt_data = 44; vt[4].aluop = 3'b011;
        vt[4].rs = 4; vt[4].rt = 6; vt[4].rd = 5; vt[4].rw = 1;
        vt[4].e_haz_pre = 1;
        // held consumer captured on the following edge
        vt[5] = vt[4];
        vt[5].e_haz_pre = 0; vt[5].e_valid = 1; vt[5].e_in1 = 33; vt[5].e_in2 = 44;
        vt[5].e_op = 3'b011; vt[5].e_rw = 1;

        for (int i = 0; i < 6; i++) begin
            apply_vec(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d_haz_pre", i), {31'd0, load_use_hazard}, {31'd0, vt[i].e_haz_pre});
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("v%0d_in1", i), alu_in1, vt[i].e_in1);
            chk($sformatf("v%0d_in2", i), alu_in2, vt[i].e_in2);
            chk($sformatf("v%0d_op", i), {29'd0, alu_op}, {29'd0, vt[i].e_op});
            chk($sformatf("v%0d_rw", i), {31'd0, ex_reg_write}, {31'd0, vt[i].e_rw});
            chk($sformatf("v%0d_haz_post", i), {31'd0, load_use_hazard}, {31'd0, vt[i].e_haz_post});
        end

        // stall and flush on the same edge: flush wins
        drive_id(1, 100, 200, 3'd5, 1, 2, 3, 1);
        @(posedge clk); #1;
        chk("cap_a_in1", alu_in1, 32'd100);
        stall = 1; flush = 1;
        drive_id(1, 1, 2, 3'd6, 7, 7, 7, 1);
        @(posedge clk); #1;
        chk("sf_valid", {31'd0, ex_valid}, 32'd0);
        chk("sf_op", {29'd0, alu_op}, 32'd0);
        chk("sf_in1", alu_in1, 32'd0);
        chk("sf_rw", {31'd0, ex_reg_write}, 32'd0);
        stall = 0; flush = 0;

        // stall alone holds for three edges
        drive_id(1, 100, 200, 3'd5, 1, 2, 3, 1);
        @(posedge clk); #1;
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            drive_id(1, $urandom, $urandom, 3'd2, 9, 10, 11, 0);
            @(posedge clk); #1;
            chk("st_valid", {31'd0, ex_valid}, 32'd1);
            chk("st_in1", alu_in1, 32'd100);
            chk("st_in2", alu_in2, 32'd200);
            chk("st_op", {29'd0, alu_op}, 32'd5);
            chk("st_rd", {27'd0, ex_rd}, 32'd3);
        end
        stall = 0;

        // asynchronous reset between edges
        drive_id(1, 55, 66, 3'd7, 1, 2, 3, 1);
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_op", {29'd0, alu_op}, 32'd0);
        chk("arst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("arst_in1", alu_in1, 32'd0);
        drive_id(1, 77, 88, 3'd4, 1, 2, 3, 1);
        @(posedge clk);
        @(negedge clk);
        chk("inrst_valid", {31'd0, ex_valid}, 32'd0);
        rst_n = 1;
        #1;
        chk("rel_valid", {31'd0, ex_valid}, 32'd0);
        @(posedge clk); #1;
        chk("first_cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("first_cap_in1", alu_in1, 32'd77);

        // randomized traffic against the model, starting from a flushed stage
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        ms = '0;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 15) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_alu_src = $urandom_range(0, 1); id_aluop = 3'($urandom_range(0, 7));
            id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_reg_write = $urandom_range(0, 1); id_mem_read = $urandom_range(0, 1);
            id_mem_write = $urandom_range(0, 1);
            exmem_reg_write = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_reg_write = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            @(negedge clk);
            check_model();
            @(posedge clk);
            ms = m_next(ms);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
